hyperram_arbiter: RTL and testbench

- Two-requester Avalon-MM arbiter placed upstream of the HyperRAM errata/controller path.
- Shares the single HyperRAM Avalon port between two masters, e.g. video scan-out and CPU.
- Round-robin, burst-aware: a write burst holds the grant until its last beat.
- Read commands release the grant immediately; an owner FIFO routes returning read beats to the correct requester.

---
 rtl/hyperram_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_hyperram_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperram_arbiter.sv
// Two-requester round-robin Avalon-MM arbiter for the HyperRAM port.
// Write bursts hold the grant until their last beat; a small owner FIFO routes read beats back to the right requester.
module hyperram_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int BURST_W   = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  output logic                  s0_avm_waitrequest_o,
  input  logic                  s0_avm_write_i,
  input  logic                  s0_avm_read_i,
  input  logic [ADDR_W-1:0]     s0_avm_address_i,
  input  logic [DATA_W-1:0]     s0_avm_writedata_i,
  input  logic [DATA_W/8-1:0]   s0_avm_byteenable_i,
  input  logic [BURST_W-1:0]    s0_avm_burstcount_i,
  output logic [DATA_W-1:0]     s0_avm_readdata_o,
  output logic                  s0_avm_readdatavalid_o,

  output logic                  s1_avm_waitrequest_o,
  input  logic                  s1_avm_write_i,
  input  logic                  s1_avm_read_i,
  input  logic [ADDR_W-1:0]     s1_avm_address_i,
  input  logic [DATA_W-1:0]     s1_avm_writedata_i,
  input  logic [DATA_W/8-1:0]   s1_avm_byteenable_i,
  input  logic [BURST_W-1:0]    s1_avm_burstcount_i,
  output logic [DATA_W-1:0]     s1_avm_readdata_o,
  output logic                  s1_avm_readdatavalid_o,

  input  logic                  m_avm_waitrequest_i,
  output logic                  m_avm_write_o,
  output logic                  m_avm_read_o,
  output logic [ADDR_W-1:0]     m_avm_address_o,
  output logic [DATA_W-1:0]     m_avm_writedata_o,
  output logic [DATA_W/8-1:0]   m_avm_byteenable_o,
  output logic [BURST_W-1:0]    m_avm_burstcount_o,
  input  logic [DATA_W-1:0]     m_avm_readdata_i,
  input  logic                  m_avm_readdatavalid_i,

  output logic                  err_o
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT0 = 2'd1;
  localparam logic [1:0] ST_GRANT1 = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               wr_active_q, wr_active_d;
  logic [BURST_W-1:0] wr_left_q, wr_left_d;
  logic               err_q, err_d;

  logic               own_q   [MAX_OUTST];
  logic [BURST_W-1:0] beats_q [MAX_OUTST];
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]   occ_q, occ_d, occ_after_pop;

  logic               sel, granted;
  logic               req0, req1;
  logic               req_rd, req_wr;
  logic [BURST_W-1:0] req_bc, bc_eff;
  logic               fifo_empty, beat, pop, push, full;
  logic               rd_cmd, rd_acc, wr_acc, wait_x;

  assign req0    = s0_avm_read_i | s0_avm_write_i;
  assign req1    = s1_avm_read_i | s1_avm_write_i;
  assign sel     = (state_q == ST_GRANT1);
  assign granted = (state_q == ST_GRANT0) | (state_q == ST_GRANT1);

  assign req_rd = sel ? s1_avm_read_i       : s0_avm_read_i;
  assign req_wr = sel ? s1_avm_write_i      : s0_avm_write_i;
  assign req_bc = sel ? s1_avm_burstcount_i : s0_avm_burstcount_i;
  assign bc_eff = (req_bc == '0) ? BURST_W'(1) : req_bc;

  assign m_avm_address_o    = sel ? s1_avm_address_i    : s0_avm_address_i;
  assign m_avm_writedata_o  = sel ? s1_avm_writedata_i  : s0_avm_writedata_i;
  assign m_avm_byteenable_o = sel ? s1_avm_byteenable_i : s0_avm_byteenable_i;
  assign m_avm_burstcount_o = bc_eff;

  // Read-return side: a beat with no outstanding owner is dropped and flagged.
  assign fifo_empty    = (occ_q == '0);
  assign beat          = m_avm_readdatavalid_i & ~fifo_empty;
  assign pop           = beat & (beats_q[rd_ptr_q] == BURST_W'(1));
  assign occ_after_pop = occ_q - CNT_W'(pop);
  assign full          = (occ_after_pop == CNT_W'(MAX_OUTST));

  // A granted read blocked by a full FIFO stalls its requester without reaching the m side.
  assign rd_cmd        = granted & req_rd & ~req_wr & ~wr_active_q;
  assign m_avm_read_o  = rd_cmd & ~full;
  assign m_avm_write_o = granted & req_wr;
  assign wait_x        = (rd_cmd & full) | m_avm_waitrequest_i;
  assign rd_acc        = m_avm_read_o & ~m_avm_waitrequest_i;
  assign wr_acc        = m_avm_write_o & ~m_avm_waitrequest_i;
  assign push          = rd_acc;

  assign s0_avm_waitrequest_o   = (state_q != ST_GRANT0) | wait_x;
  assign s1_avm_waitrequest_o   = (state_q != ST_GRANT1) | wait_x;
  assign s0_avm_readdata_o      = m_avm_readdata_i;
  assign s1_avm_readdata_o      = m_avm_readdata_i;
  assign s0_avm_readdatavalid_o = beat & ~own_q[rd_ptr_q];
  assign s1_avm_readdatavalid_o = beat &  own_q[rd_ptr_q];
  assign err_o                  = err_q;

  assign occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wr_active_d  = wr_active_q;
    wr_left_d    = wr_left_q;
    err_d        = err_q | (m_avm_readdatavalid_i & fifo_empty);
    case (state_q)
      ST_IDLE: begin
        if (req0 && (!req1 || last_grant_q)) begin
          state_d      = ST_GRANT0;
          last_grant_d = 1'b0;
        end else if (req1) begin
          state_d      = ST_GRANT1;
          last_grant_d = 1'b1;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (rd_acc) begin
          state_d = ST_IDLE;
        end else if (wr_acc) begin
          if (!wr_active_q) begin
            if (bc_eff == BURST_W'(1)) begin
              state_d = ST_IDLE;
            end else begin
              wr_active_d = 1'b1;
              wr_left_d   = bc_eff - BURST_W'(1);
            end
          end else if (wr_left_q == BURST_W'(1)) begin
            state_d     = ST_IDLE;
            wr_active_d = 1'b0;
            wr_left_d   = '0;
          end else begin
            wr_left_d = wr_left_q - BURST_W'(1);
          end
        end else if (!req_rd && !req_wr && !wr_active_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      wr_active_q  <= 1'b0;
      wr_left_q    <= '0;
      err_q        <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wr_active_q  <= wr_active_d;
      wr_left_q    <= wr_left_d;
      err_q        <= err_d;
      occ_q        <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; occupancy alone defines which slots are live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      own_q[wr_ptr_q]   <= sel;
      beats_q[wr_ptr_q] <= bc_eff;
    end
    if (beat && !pop) beats_q[rd_ptr_q] <= beats_q[rd_ptr_q] - BURST_W'(1);
  end

endmodule

// File: tb/tb_hyperram_arbiter.sv
// Self-checking bench for hyperram_arbiter: requester agents and a transaction-level
// model (grant owner, queue of outstanding reads, write beat tally) checked every cycle.
module tb_hyperram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        s0_wait, s0_write, s0_read, s0_rdv;
  logic [31:0] s0_addr;
  logic [15:0] s0_wdata, s0_rdata;
  logic [1:0]  s0_be;
  logic [7:0]  s0_bc;
  logic        s1_wait, s1_write, s1_read, s1_rdv;
  logic [31:0] s1_addr;
  logic [15:0] s1_wdata, s1_rdata;
  logic [1:0]  s1_be;
  logic [7:0]  s1_bc;
  logic        m_wait, m_write, m_read, m_rdv, err;
  logic [31:0] m_addr;
  logic [15:0] m_wdata, m_rdata;
  logic [1:0]  m_be;
  logic [7:0]  m_bc;

  hyperram_arbiter dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s0_avm_waitrequest_o(s0_wait), .s0_avm_write_i(s0_write), .s0_avm_read_i(s0_read),
    .s0_avm_address_i(s0_addr), .s0_avm_writedata_i(s0_wdata), .s0_avm_byteenable_i(s0_be),
    .s0_avm_burstcount_i(s0_bc), .s0_avm_readdata_o(s0_rdata), .s0_avm_readdatavalid_o(s0_rdv),
    .s1_avm_waitrequest_o(s1_wait), .s1_avm_write_i(s1_write), .s1_avm_read_i(s1_read),
    .s1_avm_address_i(s1_addr), .s1_avm_writedata_i(s1_wdata), .s1_avm_byteenable_i(s1_be),
    .s1_avm_burstcount_i(s1_bc), .s1_avm_readdata_o(s1_rdata), .s1_avm_readdatavalid_o(s1_rdv),
    .m_avm_waitrequest_i(m_wait), .m_avm_write_o(m_write), .m_avm_read_o(m_read),
    .m_avm_address_o(m_addr), .m_avm_writedata_o(m_wdata), .m_avm_byteenable_o(m_be),
    .m_avm_burstcount_o(m_bc), .m_avm_readdata_i(m_rdata), .m_avm_readdatavalid_i(m_rdv),
    .err_o(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // requester agents
  int          a_mode [2];   // 0 idle, 1 read, 2 write burst
  logic [7:0]  a_bc   [2];
  int          a_sent [2];
  logic [31:0] a_addr [2];
  logic        d_rd [2], d_wr [2];
  logic [15:0] d_wd [2];
  logic [1:0]  d_be [2];

  // knobs
  bit rand_en = 0;
  int gap_pct = 0;
  int wait_mode = 0;  // 0 ready, 1 toggling, 2 random
  int rdv_mode = 0;   // 0 none, 1 random, 2 every cycle
  bit force_rdv = 0;
  bit tog = 0;

  // reference model
  int g_own = -1;
  int g_last = 1;
  int w_done = 0, w_total = 0;
  bit e_err = 0;
  int q_own[$];
  int q_cnt[$];

  int acc_own[$];
  int rdv_own[$];
  logic obs_mrd, obs_w0;

  function automatic int eff(input logic [7:0] b);
    return (b == 8'd0) ? 1 : int'(b);
  endfunction

  task automatic start_agent(input int a, input int mode, input int bc, input logic [31:0] addr);
    a_mode[a] = mode;
    a_bc[a]   = 8'(bc);
    a_sent[a] = 0;
    a_addr[a] = addr;
  endtask

  task automatic step();
    bit e_mrd, e_mwr, is_rd, popping, full;
    bit e_w[2], e_v[2];
    int g;
    for (int a = 0; a < 2; a++) begin
      d_rd[a] = (a_mode[a] == 1);
      d_wr[a] = (a_mode[a] == 2) && !(a_sent[a] > 0 && gap_pct > 0 && $urandom_range(99) < gap_pct);
      d_wd[a] = 16'($urandom);
      d_be[a] = 2'($urandom);
    end
    tog = ~tog;
    m_wait = (wait_mode == 1) ? tog : (wait_mode == 2) ? ($urandom_range(2) == 0) : 1'b0;
    m_rdv  = force_rdv || (rdv_mode == 1 && q_own.size() > 0 && $urandom_range(1) == 1)
             || (rdv_mode == 2 && q_own.size() > 0);
    m_rdata = 16'($urandom);
    s0_read = d_rd[0]; s0_write = d_wr[0]; s0_addr = a_addr[0]; s0_wdata = d_wd[0];
    s0_be = d_be[0]; s0_bc = a_bc[0];
    s1_read = d_rd[1]; s1_write = d_wr[1]; s1_addr = a_addr[1]; s1_wdata = d_wd[1];
    s1_be = d_be[1]; s1_bc = a_bc[1];

    @(negedge clk);
    g = g_own;
    popping = m_rdv && q_own.size() > 0 && q_cnt[0] == 1;
    full = (q_own.size() - int'(popping)) >= 4;
    e_mrd = 0; e_mwr = 0; e_w[0] = 1; e_w[1] = 1; is_rd = 0;
    if (g >= 0) begin
      is_rd = d_rd[g] && !d_wr[g] && w_done == 0;
      e_mrd = is_rd && !full;
      e_mwr = d_wr[g];
      e_w[g] = (is_rd && full) || m_wait;
    end
    for (int o = 0; o < 2; o++) e_v[o] = m_rdv && q_own.size() > 0 && q_own[0] == o;

    chk("m_read", m_read, e_mrd);
    chk("m_write", m_write, e_mwr);
    chk("s0_wait", s0_wait, e_w[0]);
    chk("s1_wait", s1_wait, e_w[1]);
    chk("s0_rdv", s0_rdv, e_v[0]);
    chk("s1_rdv", s1_rdv, e_v[1]);
    chk("err", err, e_err);
    chk("s0_rdata", s0_rdata, m_rdata);
    chk("s1_rdata", s1_rdata, m_rdata);
    if (g >= 0 && (e_mrd || e_mwr)) begin
      chk("m_addr", m_addr, a_addr[g]);
      chk("m_bc", m_bc, eff(a_bc[g]));
      if (e_mwr) begin
        chk("m_wdata", m_wdata, d_wd[g]);
        chk("m_be", m_be, d_be[g]);
      end
    end

    obs_mrd = m_read;
    obs_w0  = s0_wait;
    if ((m_read || m_write) && !m_wait) acc_own.push_back(!s0_wait ? 0 : (!s1_wait ? 1 : -1));
    if (s0_rdv) rdv_own.push_back(0);
    if (s1_rdv) rdv_own.push_back(1);

    // agents advance on model-predicted acceptance
    if (g >= 0) begin
      if (a_mode[g] == 1 && e_mrd && !m_wait) a_mode[g] = 0;
      else if (a_mode[g] == 2 && e_mwr && !m_wait) begin
        a_sent[g]++;
        if (a_sent[g] == eff(a_bc[g])) a_mode[g] = 0;
      end
    end

    // model: read returns
    if (m_rdv) begin
      if (q_own.size() > 0) begin
        q_cnt[0] = q_cnt[0] - 1;
        if (q_cnt[0] == 0) begin
          void'(q_own.pop_front());
          void'(q_cnt.pop_front());
        end
      end else e_err = 1;
    end
    // model: grant ownership
    if (g < 0) begin
      if ((d_rd[0] || d_wr[0]) && (d_rd[1] || d_wr[1])) g_own = (g_last == 1) ? 0 : 1;
      else if (d_rd[0] || d_wr[0]) g_own = 0;
      else if (d_rd[1] || d_wr[1]) g_own = 1;
      if (g_own >= 0) g_last = g_own;
    end else if (e_mrd && !m_wait) begin
      q_own.push_back(g);
      q_cnt.push_back(eff(a_bc[g]));
      g_own = -1;
    end else if (e_mwr && !m_wait) begin
      if (w_done == 0) w_total = eff(a_bc[g]);
      w_done++;
      if (w_done == w_total) begin
        w_done = 0;
        g_own = -1;
      end
    end else if (!d_rd[g] && !d_wr[g] && w_done == 0) g_own = -1;

    if (!rst_n) begin
      g_own = -1; g_last = 1; w_done = 0; e_err = 0;
      q_own.delete(); q_cnt.delete();
      a_mode[0] = 0; a_mode[1] = 0;
    end
    if (rand_en) begin
      for (int a = 0; a < 2; a++)
        if (a_mode[a] == 0 && $urandom_range(3) == 0)
          start_agent(a, ($urandom_range(1) == 1) ? 1 : 2, $urandom_range(4), $urandom);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_idle(input int bound);
    int i = 0;
    while ((a_mode[0] != 0 || a_mode[1] != 0 || g_own >= 0) && i < bound) begin
      step();
      i++;
    end
    chk("idle_timeout", (a_mode[0] == 0 && a_mode[1] == 0 && g_own < 0), 1);
  endtask

  task automatic drain();
    int i = 0;
    int save = rdv_mode;
    rdv_mode = 2;
    while (q_own.size() > 0 && i < 300) begin
      step();
      i++;
    end
    chk("drain_timeout", q_own.size(), 0);
    rdv_mode = save;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    rst_n = 1;
  endtask

  initial begin
    a_mode[0] = 0; a_mode[1] = 0;
    a_bc[0] = 1; a_bc[1] = 1; a_sent[0] = 0; a_sent[1] = 0; a_addr[0] = 0; a_addr[1] = 0;
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    s0_addr = 0; s1_addr = 0; s0_wdata = 0; s1_wdata = 0; s0_be = 0; s1_be = 0;
    s0_bc = 1; s1_bc = 1; m_wait = 0; m_rdv = 0; m_rdata = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // single read, s0 burst 4, command one cycle after request
    start_agent(0, 1, 4, 32'h100);
    step();
    chk("single_lat_n", obs_mrd, 0);
    step();
    chk("single_lat_n1", obs_mrd, 1);
    run_until_idle(20);
    rdv_own.delete();
    drain();
    chk("single_beats", rdv_own.size(), 4);
    foreach (rdv_own[i]) chk("single_owner", rdv_own[i], 0);

    // contention: tied single-beat writes alternate starting with s0
    do_reset();
    acc_own.delete();
    for (int r = 0; r < 9; r++) begin
      start_agent(0, 2, 1, 32'h200 + r);
      start_agent(1, 2, 1, 32'h300 + r);
      run_until_idle(20);
    end
    chk("contend_count", acc_own.size(), 18);
    foreach (acc_own[i]) chk("contend_order", acc_own[i], i % 2);

    // write burst of 8 from s1 holds grant against a pending s0 read
    acc_own.delete();
    wait_mode = 1;
    start_agent(1, 2, 8, 32'h400);
    step();
    start_agent(0, 1, 2, 32'h500);
    run_until_idle(100);
    wait_mode = 0;
    chk("hold_count", acc_own.size(), 9);
    for (int i = 0; i < 8 && i < acc_own.size(); i++) chk("hold_s1", acc_own[i], 1);
    if (acc_own.size() > 8) chk("hold_s0_last", acc_own[8], 0);
    drain();

    // interleaved reads return in issue order
    start_agent(0, 1, 2, 32'h600); run_until_idle(20);
    start_agent(1, 1, 3, 32'h700); run_until_idle(20);
    start_agent(0, 1, 1, 32'h800); run_until_idle(20);
    rdv_own.delete();
    rdv_mode = 2;
    repeat (8) step();
    rdv_mode = 0;
    chk("ilv_count", rdv_own.size(), 6);
    for (int i = 0; i < 6 && i < rdv_own.size(); i++) chk("ilv_owner", rdv_own[i], (i == 2 || i == 3 || i == 4) ? 1 : 0);

    // FIFO full: four outstanding reads block the fifth until a slot frees
    for (int k = 0; k < 4; k++) begin
      start_agent(k % 2, 1, 1, 32'h900 + k);
      run_until_idle(20);
    end
    start_agent(0, 1, 2, 32'hA00);
    repeat (3) step();
    chk("full_mread", obs_mrd, 0);
    chk("full_wait", obs_w0, 1);
    force_rdv = 1;
    step();
    force_rdv = 0;
    run_until_idle(10);
    chk("full_occ", q_own.size(), 4);
    drain();

    // randomized traffic
    rand_en = 1; gap_pct = 20; wait_mode = 2; rdv_mode = 1;
    repeat (2000) step();
    rand_en = 0; gap_pct = 0; wait_mode = 0;
    run_until_idle(200);
    drain();
    rdv_mode = 0;

    // stray read beat sets sticky error
    force_rdv = 1;
    step();
    force_rdv = 0;
    step();
    chk("err_set", err, 1);
    repeat (5) step();
    chk("err_sticky", err, 1);

    // reset in the middle of a write burst
    start_agent(1, 2, 8, 32'hB00);
    repeat (4) step();
    do_reset();
    step();
    chk("rst_mwrite", m_write, 0);
    chk("rst_s1wait", s1_wait, 1);
    chk("rst_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
